// File: rtl/lrs_pkg.sv
// Shared types and default configuration for the load/run/dump sequencer.
// The optional RUN watchdog is enabled by defining LRS_RUN_TIMEOUT_EN.
package lrs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IM  = 3'd1,
        ST_LOAD_DM  = 3'd2,
        ST_RUN      = 3'd3,
        ST_DUMP_RD  = 3'd4,
        ST_DUMP_OUT = 3'd5
    } lrs_state_e;

    localparam logic [15:0] LRS_DONE_ADDR_DEFAULT      = 16'hFFFF;
    localparam logic [15:0] LRS_DUMP_BASE_DEFAULT      = 16'h0000;
    localparam logic [15:0] LRS_DUMP_LEN_DEFAULT       = 16'd16;
    localparam logic [31:0] LRS_TIMEOUT_CYCLES_DEFAULT = 32'd1_000_000;

    function automatic logic isLoadState(input lrs_state_e s);
        return (s == ST_LOAD_IM) || (s == ST_LOAD_DM);
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// Counts consecutive cycles with enable high and flags expiry on the
// TIMEOUT_CYCLES-th one; only instantiated when LRS_RUN_TIMEOUT_EN is defined.
module run_watchdog
    import lrs_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = LRS_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic expired
);

    logic [31:0] r_count;
    logic        w_atLimit;

    assign w_atLimit = (r_count == (TIMEOUT_CYCLES - 32'd1));
    assign expired   = enable && w_atLimit;

    // Counter restarts whenever the sequencer leaves RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!enable) begin
            r_count <= '0;
        end else if (!w_atLimit) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/load_run_sequencer.sv
// Loads IM/DM from a host byte stream, releases the processor until it writes
// DONE_ADDR, then streams a DM window back out. Watchdog: LRS_RUN_TIMEOUT_EN.
module load_run_sequencer
    import lrs_pkg::*;
#(
    parameter logic [15:0] DONE_ADDR      = LRS_DONE_ADDR_DEFAULT,
    parameter logic [15:0] DUMP_BASE      = LRS_DUMP_BASE_DEFAULT,
    parameter logic [15:0] DUMP_LEN       = LRS_DUMP_LEN_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES = LRS_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] im_len,
    input  logic [15:0] dm_len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        proc_rst_n,
    input  logic [15:0] proc_addr,
    input  logic [15:0] proc_wdata,
    input  logic        proc_dm_wr,
    input  logic        proc_im_wr,
    input  logic [7:0]  dm_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        dm_wr,
    output logic        im_wr,
    output logic        busy,
    output logic        timeout
);

    lrs_state_e  r_state;
    logic [15:0] r_imLen;
    logic [15:0] r_dmLen;
    logic [15:0] r_idx;
    logic [15:0] r_dumpIdx;
    logic        r_rdWait;
    logic [7:0]  r_outData;

    logic w_handshake;
    logic w_lastIm;
    logic w_lastDm;
    logic w_doneWrite;
    logic w_lastDump;
    logic w_expired;

    // Handshake flags are straight decodes of the state register.
    assign in_ready   = isLoadState(r_state);
    assign out_valid  = (r_state == ST_DUMP_OUT);
    assign busy       = (r_state != ST_IDLE);
    assign proc_rst_n = (r_state == ST_RUN);
    assign out_data   = r_outData;

    assign w_handshake = in_valid && in_ready;
    assign w_lastIm    = (r_idx == (r_imLen - 16'd1));
    assign w_lastDm    = (r_idx == (r_dmLen - 16'd1));
    assign w_doneWrite = proc_dm_wr && (proc_addr == DONE_ADDR);
    assign w_lastDump  = (r_dumpIdx == (DUMP_LEN - 16'd1));

`ifdef LRS_RUN_TIMEOUT_EN
    logic r_timeout;
    logic w_unusedProcHigh;

    run_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (r_state == ST_RUN),
        .expired (w_expired)
    );

    assign timeout          = r_timeout;
    assign w_unusedProcHigh = ^proc_wdata[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_RUN) && !w_doneWrite && w_expired) begin
            r_timeout <= 1'b1;
        end
    end
`else
    logic w_unusedProcHigh;

    assign w_expired        = 1'b0;
    assign timeout          = 1'b0;
    assign w_unusedProcHigh = ^{proc_wdata[15:8], TIMEOUT_CYCLES};
`endif

    // Memory port mux: host bytes while loading, processor while running,
    // dump reader afterwards, idle zeros otherwise.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        dm_wr     = 1'b0;
        im_wr     = 1'b0;
        unique case (r_state)
            ST_LOAD_IM: begin
                mem_addr  = r_idx;
                mem_wdata = in_data;
                im_wr     = in_valid;
            end
            ST_LOAD_DM: begin
                mem_addr  = r_idx;
                mem_wdata = in_data;
                dm_wr     = in_valid;
            end
            ST_RUN: begin
                mem_addr  = proc_addr;
                mem_wdata = proc_wdata[7:0];
                dm_wr     = proc_dm_wr;
                im_wr     = proc_im_wr;
            end
            ST_DUMP_RD: begin
                mem_addr = DUMP_BASE + r_dumpIdx;
            end
            default: begin
            end
        endcase
    end

    // DUMP_RD holds the address for two cycles: one for the DM read latency,
    // one to capture dm_rdata, so out_data is already stable in DUMP_OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_imLen   <= '0;
            r_dmLen   <= '0;
            r_idx     <= '0;
            r_dumpIdx <= '0;
            r_rdWait  <= 1'b0;
            r_outData <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_imLen   <= im_len;
                        r_dmLen   <= dm_len;
                        r_idx     <= '0;
                        r_dumpIdx <= '0;
                        if (im_len != 16'd0) begin
                            r_state <= ST_LOAD_IM;
                        end else if (dm_len != 16'd0) begin
                            r_state <= ST_LOAD_DM;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_LOAD_IM: begin
                    if (w_handshake) begin
                        if (w_lastIm) begin
                            r_idx   <= '0;
                            r_state <= (r_dmLen != 16'd0) ? ST_LOAD_DM : ST_RUN;
                        end else begin
                            r_idx <= r_idx + 16'd1;
                        end
                    end
                end
                ST_LOAD_DM: begin
                    if (w_handshake) begin
                        if (w_lastDm) begin
                            r_idx   <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_idx <= r_idx + 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_doneWrite || w_expired) begin
                        r_dumpIdx <= '0;
                        r_rdWait  <= 1'b0;
                        r_state   <= ST_DUMP_RD;
                    end
                end
                ST_DUMP_RD: begin
                    if (!r_rdWait) begin
                        r_rdWait <= 1'b1;
                    end else begin
                        r_rdWait  <= 1'b0;
                        r_outData <= dm_rdata;
                        r_state   <= ST_DUMP_OUT;
                    end
                end
                ST_DUMP_OUT: begin
                    if (out_ready) begin
                        if (w_lastDump) begin
                            r_dumpIdx <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_dumpIdx <= r_dumpIdx + 16'd1;
                            r_state   <= ST_DUMP_RD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_run_sequencer.sv
// Directed bench for load_run_sequencer: table-driven load/run vectors plus
// hand-written dump, stall, zero-length, watchdog and reset sequences.
module tb_load_run_sequencer;

    localparam logic [15:0] P_DONE_ADDR = 16'hFFFF;
    localparam logic [15:0] P_DUMP_BASE = 16'h0010;
    localparam logic [15:0] P_DUMP_LEN  = 16'd4;
    localparam logic [31:0] P_TIMEOUT   = 32'd100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] im_len;
    logic [15:0] dm_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        proc_rst_n;
    logic [15:0] proc_addr;
    logic [15:0] proc_wdata;
    logic        proc_dm_wr;
    logic        proc_im_wr;
    logic [7:0]  dm_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        dm_wr;
    logic        im_wr;
    logic        busy;
    logic        timeout;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] dmMem [0:65535];
    logic [7:0] imMem [0:65535];

    typedef struct {
        logic        inValid;
        logic [7:0]  inData;
        logic [15:0] pAddr;
        logic [15:0] pWdata;
        logic        pDm;
        logic        pIm;
        logic        eInReady;
        logic        eImWr;
        logic        eDmWr;
        logic [15:0] eAddr;
        logic [7:0]  eWdata;
        logic        eProcRst;
        logic        eBusy;
    } vec_t;

    vec_t vecs [12];

    load_run_sequencer #(
        .DONE_ADDR      (P_DONE_ADDR),
        .DUMP_BASE      (P_DUMP_BASE),
        .DUMP_LEN       (P_DUMP_LEN),
        .TIMEOUT_CYCLES (P_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .im_len     (im_len),
        .dm_len     (dm_len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .proc_rst_n (proc_rst_n),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_dm_wr (proc_dm_wr),
        .proc_im_wr (proc_im_wr),
        .dm_rdata   (dm_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dm_wr      (dm_wr),
        .im_wr      (im_wr),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Memory model: writes on the clock, DM read data one cycle after the address.
    always @(posedge clk) begin
        if (dm_wr) dmMem[mem_addr] <= mem_wdata;
        if (im_wr) imMem[mem_addr] <= mem_wdata;
        dm_rdata <= dmMem[mem_addr];
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_time_limit actual=expired required=finished");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid   = v.inValid;
        in_data    = v.inData;
        proc_addr  = v.pAddr;
        proc_wdata = v.pWdata;
        proc_dm_wr = v.pDm;
        proc_im_wr = v.pIm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearProc();
        proc_addr  = 16'h0000;
        proc_wdata = 16'h0000;
        proc_dm_wr = 1'b0;
        proc_im_wr = 1'b0;
    endtask

    // Called on entry to DUMP_RD; waits for out_valid, optionally stalls, then accepts.
    task automatic getByte(input int idx, input bit stall, input logic [7:0] expData);
        int         waitCycles;
        logic [7:0] held;
        logic       stallOk;
        checkOutput($sformatf("dump%0d_rd_addr", idx), {16'h0, mem_addr}, {16'h0, P_DUMP_BASE + 16'(idx)});
        checkOutput($sformatf("dump%0d_rd_wr", idx), {30'h0, dm_wr, im_wr}, 32'h0);
        waitCycles = 0;
        while (!out_valid && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput($sformatf("dump%0d_valid", idx), {31'h0, out_valid}, 32'h1);
        if (stall) begin
            held    = out_data;
            stallOk = 1'b1;
            repeat (10) begin
                tick();
                if (!out_valid || out_data !== held) stallOk = 1'b0;
            end
            checkOutput($sformatf("dump%0d_stall_hold", idx), {31'h0, stallOk}, 32'h1);
        end
        checkOutput($sformatf("dump%0d_data", idx), {24'h0, out_data}, {24'h0, expData});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput($sformatf("dump%0d_gap", idx), {31'h0, out_valid}, 32'h0);
    endtask

    task automatic dumpAll();
        logic [7:0] expBytes [4];
        expBytes[0] = 8'hAA;
        expBytes[1] = 8'h11;
        expBytes[2] = 8'h12;
        expBytes[3] = 8'h13;
        for (int i = 0; i < 4; i++) getByte(i, (i == 1), expBytes[i]);
        checkOutput("dump_end_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int runCycles;
        int expRun;

        for (int i = 0; i < 65536; i++) begin
            dmMem[i] = 8'h00;
            imMem[i] = 8'h00;
        end

        //            inV  inData  pAddr     pWdata    pDm  pIm  rdy  imW  dmW  addr      wdata  pRst busy
        vecs[0]  = '{1'b1, 8'hA1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'hA1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 8'hA2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 8'hA2, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'hA3, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 8'hA3, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'hB1, 16'h1234, 16'h0099, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'hB1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'hB2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 8'hB2, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'hC3, 16'h0005, 16'h01EE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0005, 8'hEE, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 16'h0010, 16'h00AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 8'hAA, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 16'h0011, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 8'h11, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 16'h0012, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0012, 8'h12, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 16'h0013, 16'h3413, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0013, 8'h13, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 16'hFFFF, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h55, 1'b1, 1'b1};

        // Reset state, with host and processor inputs active to show they are ignored.
        rst_n     = 1'b0;
        start     = 1'b0;
        im_len    = 16'd0;
        dm_len    = 16'd0;
        in_data   = 8'h5C;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        proc_addr = 16'h0042;
        proc_wdata = 16'h0077;
        proc_dm_wr = 1'b1;
        proc_im_wr = 1'b1;
        repeat (3) tick();
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_proc_rst_n", {31'h0, proc_rst_n}, 32'h0);
        checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset_out_data", {24'h0, out_data}, 32'h0);
        checkOutput("reset_timeout", {31'h0, timeout}, 32'h0);
        checkOutput("reset_mem_bus", {mem_addr, mem_wdata, 6'h0, dm_wr, im_wr}, 32'h0);
        in_valid = 1'b0;
        clearProc();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_mem_bus", {mem_addr, mem_wdata, 6'h0, dm_wr, im_wr}, 32'h0);

        // Full job: im_len=3, dm_len=2, then processor run ending on the done write.
        start  = 1'b1;
        im_len = 16'd3;
        dm_len = 16'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].eInReady});
            checkOutput($sformatf("vec%0d_im_wr", i), {31'h0, im_wr}, {31'h0, vecs[i].eImWr});
            checkOutput($sformatf("vec%0d_dm_wr", i), {31'h0, dm_wr}, {31'h0, vecs[i].eDmWr});
            checkOutput($sformatf("vec%0d_mem_addr", i), {16'h0, mem_addr}, {16'h0, vecs[i].eAddr});
            checkOutput($sformatf("vec%0d_mem_wdata", i), {24'h0, mem_wdata}, {24'h0, vecs[i].eWdata});
            checkOutput($sformatf("vec%0d_proc_rst_n", i), {31'h0, proc_rst_n}, {31'h0, vecs[i].eProcRst});
            checkOutput($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].eBusy});
            tick();
        end
        in_valid = 1'b0;

        // Now in DUMP_RD: processor held, its writes ignored.
        proc_addr  = 16'h0020;
        proc_wdata = 16'h00EE;
        proc_dm_wr = 1'b1;
        #1;
        checkOutput("done_proc_rst_n", {31'h0, proc_rst_n}, 32'h0);
        checkOutput("done_busy", {31'h0, busy}, 32'h1);
        checkOutput("done_timeout", {31'h0, timeout}, 32'h0);
        dumpAll();
        clearProc();
        checkOutput("mem_im_bytes", {imMem[0], imMem[1], imMem[2], imMem[5]}, 32'hA1A2A3EE);
        checkOutput("mem_dm_bytes", {dmMem[0], dmMem[1], dmMem[16'hFFFF], dmMem[16'h0020]}, 32'hB1B25500);

        // Zero-length job goes straight to RUN; a start while busy is ignored.
        start  = 1'b1;
        im_len = 16'd0;
        dm_len = 16'd0;
        tick();
        start = 1'b0;
        checkOutput("zero_proc_rst_n", {31'h0, proc_rst_n}, 32'h1);
`ifdef LRS_RUN_TIMEOUT_EN
        expRun = 100;
`else
        expRun = 150;
`endif
        runCycles = 0;
        while (proc_rst_n && runCycles < 150) begin
            runCycles++;
            start    = (runCycles == 3);
            im_len   = 16'd5;
            in_valid = 1'b1;
            in_data  = 8'h3C;
            if (runCycles == 5) begin
                checkOutput("run_in_ready", {31'h0, in_ready}, 32'h0);
                checkOutput("run_no_wr", {30'h0, dm_wr, im_wr}, 32'h0);
            end
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("run_cycles", runCycles, expRun);
        if (proc_rst_n) begin
            proc_addr  = P_DONE_ADDR;
            proc_wdata = 16'h0066;
            proc_dm_wr = 1'b1;
            tick();
            clearProc();
        end
        checkOutput("run_end_proc_rst_n", {31'h0, proc_rst_n}, 32'h0);
`ifdef LRS_RUN_TIMEOUT_EN
        checkOutput("timeout_flag", {31'h0, timeout}, 32'h1);
`else
        checkOutput("timeout_flag", {31'h0, timeout}, 32'h0);
`endif
        dumpAll();
`ifdef LRS_RUN_TIMEOUT_EN
        checkOutput("timeout_sticky", {31'h0, timeout}, 32'h1);
`endif
        start  = 1'b1;
        im_len = 16'd0;
        dm_len = 16'd0;
        tick();
        start = 1'b0;
        checkOutput("restart_timeout_clear", {31'h0, timeout}, 32'h0);

        // Reset mid-RUN returns to IDLE; then a job reset mid-LOAD_DM.
        rst_n = 1'b0;
        #1;
        checkOutput("rst_run_proc_rst_n", {31'h0, proc_rst_n}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start  = 1'b1;
        im_len = 16'd1;
        dm_len = 16'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_data = 8'hC0;
        tick();
        start   = 1'b1;
        im_len  = 16'd0;
        dm_len  = 16'd0;
        in_data = 8'hC1;
        #1;
        checkOutput("ldm_addr1", {15'h0, dm_wr, mem_addr}, {15'h0, 1'b1, 16'h0001});
        tick();
        start   = 1'b0;
        in_data = 8'hC2;
        #1;
        checkOutput("busy_start_ignored", {14'h0, in_ready, dm_wr, mem_addr}, {14'h0, 2'b11, 16'h0002});
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ldm_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_ldm_proc_rst_n", {31'h0, proc_rst_n}, 32'h0);
        checkOutput("rst_ldm_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("rst_ldm_mem_bus", {mem_addr, mem_wdata, 6'h0, dm_wr, im_wr}, 32'h0);
        repeat (2) tick();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("post_rst%0d_idle", i), {30'h0, out_valid, busy}, 32'h0);
        end
        checkOutput("mem_after_abort", {imMem[0], dmMem[0], dmMem[1], dmMem[2]}, 32'h5AC0C100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/load_run_sequencer.md
LOAD_RUN_SEQUENCER -- requirements
Module: load_run_sequencer

Interface
REQ-001 SHALL have parameter DONE_ADDR, default 16'hFFFF, meaning the DM address whose processor write signals completion.
REQ-002 SHALL have parameter DUMP_BASE, default 16'h0000, meaning the first DM address read out after the run.
REQ-003 SHALL have parameter DUMP_LEN, default 16'd16, meaning the number of result bytes dumped (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000, meaning the RUN-cycle limit, used only with the macro in REQ-025.
REQ-005 SHALL have ports:
 clk  in  1  single system clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 start  in  1  one-cycle request to begin a load/run/dump job
 im_len  in  16  instruction byte count, sampled on accepted start
 dm_len  in  16  data byte count, sampled on accepted start
 in_data  in  8  host byte stream
 in_valid  in  1  in_data valid
 in_ready  out  1  sequencer accepts in_data
 out_data  out  8  dumped result byte
 out_valid  out  1  out_data valid
 out_ready  in  1  host accepts out_data
 proc_rst_n  out  1  processor hold (0 = held)
 proc_addr  in  16  processor memory address
 proc_wdata  in  16  processor write data (low byte used)
 proc_dm_wr  in  1  processor DM write
 proc_im_wr  in  1  processor IM write
 dm_rdata  in  8  DM read data, 1-cycle synchronous latency
 mem_addr  out  16  muxed memory address
 mem_wdata  out  8  muxed write data
 dm_wr  out  1  muxed DM write enable
 im_wr  out  1  muxed IM write enable
 busy  out  1  job in progress
 timeout  out  1  last job ended by watchdog

Function
REQ-006 SHALL implement FSM states IDLE, LOAD_IM, LOAD_DM, RUN, DUMP_RD, DUMP_OUT.
REQ-007 IDLE: start accepted -> latch lengths, clear timeout, go LOAD_IM (im_len!=0), else LOAD_DM (dm_len!=0), else RUN.
REQ-008 start while busy=1 SHALL be ignored.
REQ-009 in_ready SHALL be 1 only in LOAD_IM/LOAD_DM; in_valid outside those states ignored.
REQ-010 LOAD_IM: each in_valid&in_ready cycle drives im_wr=1, mem_addr=byte index (0..im_len-1), mem_wdata=in_data, same cycle; after last byte go LOAD_DM, or RUN if dm_len==0.
REQ-011 LOAD_DM: identical with dm_wr=1, index restarting at 0; after last byte go RUN.
REQ-012 Index counter SHALL be 16 bits; im_len=16'hFFFF writes addresses 0..FFFE without wrap.
REQ-013 RUN: proc_rst_n=1; mem_addr/mem_wdata/dm_wr/im_wr SHALL pass proc_addr/proc_wdata[7:0]/proc_dm_wr/proc_im_wr combinationally.
REQ-014 RUN: proc_dm_wr=1 with proc_addr==DONE_ADDR SHALL complete that write to memory, then next cycle proc_rst_n=0 and state DUMP_RD.
REQ-015 Outside RUN, proc_rst_n SHALL be 0 and processor memory inputs ignored.
REQ-016 DUMP_RD: drive mem_addr=DUMP_BASE+k (16-bit wrap), no write enables; next cycle capture dm_rdata into out_data, go DUMP_OUT.
REQ-017 DUMP_OUT: out_valid=1, out_data stable until out_valid&out_ready; then k+1, back to DUMP_RD, or IDLE after k=DUMP_LEN-1.
REQ-018 Dump byte rate SHALL be at most one per two cycles; out_ready low SHALL stall indefinitely without loss.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Outside LOAD/RUN, dm_wr and im_wr SHALL be 0.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, proc_rst_n=0, in_ready=0, out_valid=0, out_data=0, busy=0, timeout=0, counters 0.
REQ-022 In IDLE/reset, mem_addr=0, mem_wdata=0, dm_wr=0, im_wr=0.
REQ-023 Reset mid-job SHALL abandon the job; no partial dump byte presented afterward.
REQ-024 Deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-025 Macro LRS_RUN_TIMEOUT_EN defined: RUN cycle counter (32-bit); reaching TIMEOUT_CYCLES without done write SHALL set timeout=1 (sticky until next accepted start) and go DUMP_RD.
REQ-026 Macro undefined: no counter, timeout tied 0, RUN waits indefinitely for done write.

Structure
REQ-027 Package lrs_pkg SHALL hold the state enum and default parameter constants.
REQ-028 Sub-module run_watchdog (clk, rst_n, enable, expired) SHALL implement the counter, instantiated only under LRS_RUN_TIMEOUT_EN.

Verification
REQ-029 im_len=3, dm_len=2, bytes A1 A2 A3 B1 B2 -> im_wr at addr 0,1,2 data A1..A3; dm_wr at addr 0,1 data B1,B2; then proc_rst_n=1.
REQ-030 RUN, proc writes 8'h55 to DONE_ADDR -> dm_wr passes through, proc_rst_n=0 next cycle, DUMP_LEN=4 bytes from DUMP_BASE emitted in order.
REQ-031 out_ready held 0 for 10 cycles during DUMP_OUT -> out_valid stays 1, out_data unchanged; resumes correctly.
REQ-032 im_len=0, dm_len=0, start -> RUN next cycle, no write enables asserted.
REQ-033 rst_n pulsed low mid-LOAD_DM -> same-cycle IDLE, proc_rst_n=0, busy=0; second start mid-job ignored.
REQ-034 With LRS_RUN_TIMEOUT_EN, TIMEOUT_CYCLES=100, no done write -> timeout=1 after 100 RUN cycles, dump proceeds.
